// File: rtl/addsub_share_ctrl_pkg.sv
// Shared types for the add/sub sharing controller.
// FSM state encoding and datapath width.
package addsub_share_ctrl_pkg;

  localparam int DW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/add_sub32.sv
// ADD_SUB32: 32-bit add/subtract with signed overflow.
// A,B,SUB in; ANS (modular result), CY_BR_OUT (signed ovf) out.
module ADD_SUB32
  import addsub_share_ctrl_pkg::*;
(
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  input  logic          SUB,
  output logic [DW-1:0] ANS,
  output logic          CY_BR_OUT
);

  logic [DW-1:0] b_eff;

  // Subtract as A + ~B + 1.
  assign b_eff = SUB ? ~B : B;
  assign ANS = A + b_eff + {{(DW-1){1'b0}}, SUB};

  // Same-sign operands giving a different-sign result.
  assign CY_BR_OUT = (A[DW-1] == b_eff[DW-1]) &&
                     (ANS[DW-1] != A[DW-1]);

endmodule

// File: rtl/addsub_rr_pick.sv
// Combinational round-robin picker: first set req bit from
// rr_ptr upward with wrap. Out: one-hot, index, any-valid.
module addsub_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [NREQ-1:0] gnt_oh,
  output logic [IDW-1:0]  gnt_idx,
  output logic            any_vld
);

  always_comb begin
    logic [IDW:0] k;
    gnt_oh  = '0;
    gnt_idx = '0;
    any_vld = 1'b0;
    k       = '0;
    for (int i = 0; i < NREQ; i++) begin
      k = {1'b0, rr_ptr} + (IDW+1)'(i);
      if (k >= (IDW+1)'(NREQ)) begin
        k = k - (IDW+1)'(NREQ);
      end
      if (!any_vld && req[k[IDW-1:0]]) begin
        any_vld            = 1'b1;
        gnt_idx            = k[IDW-1:0];
        gnt_oh[k[IDW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/addsub_share_ctrl.sv
// Shares one ADD_SUB32 among NREQ requesters (RR arbitration).
// Ports: per-requester REQ/RSP valid-ready, packed A/B, SUB;
// RSP_ANS/OVF/ID result; OVF_CLR/OVF_STICKY sticky overflow,
// active only with ADDSUB_SHARE_OVF_STICKY_EN defined.
module addsub_share_ctrl
  import addsub_share_ctrl_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NREQ-1:0]   REQ_VALID,
  output logic [NREQ-1:0]   REQ_READY,
  input  logic [NREQ*DW-1:0] REQ_A,
  input  logic [NREQ*DW-1:0] REQ_B,
  input  logic [NREQ-1:0]   REQ_SUB,
  output logic [NREQ-1:0]   RSP_VALID,
  input  logic [NREQ-1:0]   RSP_READY,
  output logic [DW-1:0]     RSP_ANS,
  output logic              RSP_OVF,
  output logic [IDW-1:0]    RSP_ID,
  input  logic [NREQ-1:0]   OVF_CLR,
  output logic [NREQ-1:0]   OVF_STICKY
);

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [DW-1:0]   op_a_q, op_a_d;
  logic [DW-1:0]   op_b_q, op_b_d;
  logic            op_sub_q, op_sub_d;
  logic [IDW-1:0]  op_id_q, op_id_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_ans_q, rsp_ans_d;
  logic            rsp_ovf_q, rsp_ovf_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;

  logic [NREQ-1:0] gnt_oh;
  logic [IDW-1:0]  gnt_idx;
  logic            any_vld;
  logic [DW-1:0]   alu_ans;
  logic            alu_ovf;
  logic [NREQ-1:0] id_oh;
  logic            rsp_hs;

  addsub_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req     (REQ_VALID),
    .rr_ptr  (rr_ptr_q),
    .gnt_oh  (gnt_oh),
    .gnt_idx (gnt_idx),
    .any_vld (any_vld)
  );

  ADD_SUB32 u_alu (
    .A         (op_a_q),
    .B         (op_b_q),
    .SUB       (op_sub_q),
    .ANS       (alu_ans),
    .CY_BR_OUT (alu_ovf)
  );

  assign REQ_READY = (state_q == IDLE) ? gnt_oh : '0;
  assign rsp_hs    = (state_q == RESP) && RSP_READY[rsp_id_q];

  always_comb begin
    id_oh          = '0;
    id_oh[op_id_q] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_sub_d    = op_sub_q;
    op_id_d     = op_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_ans_d   = rsp_ans_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_id_d    = rsp_id_q;
    unique case (state_q)
      IDLE: begin
        if (any_vld) begin
          op_a_d   = REQ_A[gnt_idx*DW +: DW];
          op_b_d   = REQ_B[gnt_idx*DW +: DW];
          op_sub_d = REQ_SUB[gnt_idx];
          op_id_d  = gnt_idx;
          rr_ptr_d = (gnt_idx == IDW'(NREQ-1)) ?
                     '0 : gnt_idx + 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        rsp_ans_d   = alu_ans;
        rsp_ovf_d   = alu_ovf;
        rsp_id_d    = op_id_q;
        rsp_valid_d = id_oh;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_hs) begin
          rsp_valid_d = '0;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = '0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_sub_q    <= 1'b0;
      op_id_q     <= '0;
      rsp_valid_q <= '0;
      rsp_ans_q   <= '0;
      rsp_ovf_q   <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_sub_q    <= op_sub_d;
      op_id_q     <= op_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_ans_q   <= rsp_ans_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign RSP_VALID = rsp_valid_q;
  assign RSP_ANS   = rsp_ans_q;
  assign RSP_OVF   = rsp_ovf_q;
  assign RSP_ID    = rsp_id_q;

`ifdef ADDSUB_SHARE_OVF_STICKY_EN
  logic [NREQ-1:0] sticky_q, sticky_d;
  logic [NREQ-1:0] sticky_set;

  // Set wins over a same-cycle clear.
  always_comb begin
    sticky_set = '0;
    if (rsp_hs && rsp_ovf_q) begin
      sticky_set = rsp_valid_q;
    end
    sticky_d = (sticky_q & ~OVF_CLR) | sticky_set;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign OVF_STICKY = sticky_q;
`else
  logic unused_ok;
  assign unused_ok  = ^{OVF_CLR, rsp_hs};
  assign OVF_STICKY = '0;
`endif

endmodule

// File: tb/tb_addsub_share_ctrl.sv
// Self-checking bench for addsub_share_ctrl: directed cases
// plus random traffic against a transaction-level model.
module tb_addsub_share_ctrl;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic [NREQ-1:0]   REQ_VALID, REQ_READY, REQ_SUB;
  logic [NREQ*32-1:0] REQ_A, REQ_B;
  logic [NREQ-1:0]   RSP_VALID, RSP_READY;
  logic [31:0]       RSP_ANS;
  logic              RSP_OVF;
  logic [IDW-1:0]    RSP_ID;
  logic [NREQ-1:0]   OVF_CLR, OVF_STICKY;

  addsub_share_ctrl #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .REQ_VALID  (REQ_VALID),
    .REQ_READY  (REQ_READY),
    .REQ_A      (REQ_A),
    .REQ_B      (REQ_B),
    .REQ_SUB    (REQ_SUB),
    .RSP_VALID  (RSP_VALID),
    .RSP_READY  (RSP_READY),
    .RSP_ANS    (RSP_ANS),
    .RSP_OVF    (RSP_OVF),
    .RSP_ID     (RSP_ID),
    .OVF_CLR    (OVF_CLR),
    .OVF_STICKY (OVF_STICKY)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Requester-side drive state.
  bit              pend[NREQ];
  logic [31:0]     pa[NREQ];
  logic [31:0]     pb[NREQ];
  bit              psub[NREQ];
  bit              auto_fill = 0;
  bit              rnd_en = 0;
  bit              rst_drv = 1;
  logic [NREQ-1:0] rdy_drv = '1;
  logic [NREQ-1:0] clr_drv = '0;

  // Model state.
  int              m_ptr = 0;
  int              m_phase = 0;
  bit              m_fresh = 1;
  logic [31:0]     m_ans = '0;
  bit              m_ovf = 0;
  int              m_id = 0;
  logic [31:0]     x_ans;
  bit              x_ovf;
  int              x_id;
  logic [NREQ-1:0] m_sticky = '0;
  int              cyc_n = 0;
  int              m_gcyc, m_vcyc;
  int              n_rsp = 0;
  logic [31:0]     l_ans;
  bit              l_ovf;
  int              l_id, l_lat;
  int              g_log[$];
  int              v_log[$];

  function automatic void ref_op(input logic [31:0] a,
                                 input logic [31:0] b,
                                 input bit sub,
                                 output logic [31:0] ans,
                                 output bit ovf);
    longint sa, sb, r, lim;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lim = 64'sh80000000;
    r   = sub ? sa - sb : sa + sb;
    ans = r[31:0];
    ovf = (r >= lim) || (r < -lim);
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(5))
      0: return 32'h7FFFFFFF;
      1: return 32'h80000000;
      2: return 32'h00000000;
      3: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic new_op(input int i);
    pend[i] = 1;
    pa[i]   = rnd_val();
    pb[i]   = rnd_val();
    psub[i] = $urandom_range(1) == 1;
  endtask

  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      REQ_VALID[i]       = pend[i];
      REQ_A[i*32 +: 32]  = pa[i];
      REQ_B[i*32 +: 32]  = pb[i];
      REQ_SUB[i]         = psub[i];
    end
    RSP_READY = rdy_drv;
    OVF_CLR   = clr_drv;
    RST_N     = ~rst_drv;
  endtask

  task automatic check_cycle();
    logic [NREQ-1:0] exp_rdy, exp_vld, set_b;
    int w;
    cyc_n++;
    exp_rdy = '0;
    exp_vld = '0;
    set_b   = '0;
    w       = -1;
    if (m_phase == 0) begin
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (m_ptr + k) % NREQ;
        if (w < 0 && REQ_VALID[j]) w = j;
      end
    end
    if (w >= 0) exp_rdy[w] = 1'b1;
    if (m_phase == 2) exp_vld[m_id] = 1'b1;
    chk("req_ready", 32'(REQ_READY), 32'(exp_rdy));
    chk("rsp_valid", 32'(RSP_VALID), 32'(exp_vld));
    if (m_phase == 2 || m_fresh) begin
      chk("rsp_ans", RSP_ANS, m_ans);
      chk("rsp_ovf", 32'(RSP_OVF), 32'(m_ovf));
      chk("rsp_id", 32'(RSP_ID), 32'(m_id));
    end
    chk("ovf_sticky", 32'(OVF_STICKY), 32'(m_sticky));
    if (!RST_N) begin
      m_phase  = 0;
      m_ptr    = 0;
      m_ans    = '0;
      m_ovf    = 0;
      m_id     = 0;
      m_sticky = '0;
      m_fresh  = 1;
      return;
    end
    m_fresh = 0;
    case (m_phase)
      0: if (w >= 0) begin
        ref_op(pa[w], pb[w], psub[w], x_ans, x_ovf);
        x_id    = w;
        m_ptr   = (w + 1) % NREQ;
        m_phase = 1;
        m_gcyc  = cyc_n;
        g_log.push_back(w);
        pend[w] = 0;
        if (auto_fill) new_op(w);
      end
      1: begin
        m_ans   = x_ans;
        m_ovf   = x_ovf;
        m_id    = x_id;
        m_phase = 2;
        m_vcyc  = cyc_n + 1;
        v_log.push_back(m_vcyc);
      end
      default: if (RSP_READY[m_id]) begin
        if (m_ovf) set_b[m_id] = 1'b1;
        m_phase = 0;
        l_ans   = m_ans;
        l_ovf   = m_ovf;
        l_id    = m_id;
        l_lat   = m_vcyc - m_gcyc;
        n_rsp++;
      end
    endcase
`ifdef ADDSUB_SHARE_OVF_STICKY_EN
    m_sticky = (m_sticky & ~OVF_CLR) | set_b;
`endif
  endtask

  task automatic rnd_drive();
    for (int i = 0; i < NREQ; i++) begin
      if (!pend[i] && $urandom_range(3) == 0) new_op(i);
      else if (pend[i] && $urandom_range(15) == 0)
        pend[i] = 0;
    end
    rdy_drv = NREQ'($urandom);
    clr_drv = ($urandom_range(7) == 0) ? NREQ'($urandom) : '0;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      if (rnd_en) rnd_drive();
      apply();
      #1;
      check_cycle();
      @(negedge CLK);
    end
  endtask

  task automatic wait_rsp(input int n0);
    int b = 0;
    while (n_rsp == n0 && b < 60) begin
      run(1);
      b++;
    end
    chk("rsp_timeout", 32'(n_rsp > n0), 32'd1);
  endtask

  task automatic wait_resp_phase();
    int b = 0;
    while (m_phase != 2 && b < 60) begin
      run(1);
      b++;
    end
    chk("resp_timeout", 32'(m_phase == 2), 32'd1);
  endtask

  task automatic run_one(input int i,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input bit sub,
                         input logic [31:0] e_ans,
                         input bit e_ovf);
    int n0;
    n0 = n_rsp;
    pend[i] = 1;
    pa[i]   = a;
    pb[i]   = b;
    psub[i] = sub;
    wait_rsp(n0);
    chk("dir_ans", l_ans, e_ans);
    chk("dir_ovf", 32'(l_ovf), 32'(e_ovf));
    chk("dir_id", 32'(l_id), 32'(i));
    chk("dir_latency", 32'(l_lat), 32'd2);
  endtask

  task automatic do_reset();
    rst_drv = 1;
    run(1);
    rst_drv = 0;
  endtask

  initial begin
    logic [31:0] s_ans;
    logic [IDW-1:0] s_id;
    int n0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 0;
      pa[i]   = '0;
      pb[i]   = '0;
      psub[i] = 0;
    end
    apply();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    // Reset still asserted: outputs must read as reset values.
    run(1);
    rst_drv = 0;

    // Single requester and arithmetic corners.
    rdy_drv = '1;
    run_one(1, 32'h5, 32'h3, 1, 32'h2, 0);
    run_one(0, 32'h7FFFFFFF, 32'h1, 0, 32'h80000000, 1);
    run_one(3, 32'h0, 32'h80000000, 1, 32'h80000000, 1);
    run_one(2, 32'h80000000, 32'h0, 1, 32'h80000000, 0);

    // Round robin with all requesters busy.
    do_reset();
    g_log.delete();
    v_log.delete();
    auto_fill = 1;
    for (int i = 0; i < NREQ; i++) new_op(i);
    n0 = n_rsp;
    for (int b = 0; b < 40 && n_rsp < n0 + 5; b++) run(1);
    auto_fill = 0;
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
    chk("rr_count", 32'(n_rsp - n0 >= 5), 32'd1);
    if (g_log.size() >= 5 && v_log.size() >= 5) begin
      for (int k = 0; k < 5; k++)
        chk("rr_order", 32'(g_log[k]), 32'(k % NREQ));
      for (int k = 0; k < 4; k++)
        chk("rr_spacing", 32'(v_log[k+1] - v_log[k]), 32'd3);
    end
    run(4);

    // Backpressure; non-winner ready bits are ignored.
    rdy_drv = '0;
    pend[3] = 1;
    pa[3] = 32'h1234_5678;
    pb[3] = 32'h0000_1111;
    psub[3] = 0;
    wait_resp_phase();
    pend[0] = 1;
    pa[0] = 32'hA;
    pb[0] = 32'hB;
    psub[0] = 1;
    s_ans = RSP_ANS;
    s_id  = RSP_ID;
    chk("bp_ans", s_ans, 32'h1234_6789);
    rdy_drv = 4'b0111;
    for (int k = 0; k < 5; k++) begin
      run(1);
      chk("bp_hold_ans", RSP_ANS, s_ans);
      chk("bp_hold_id", 32'(RSP_ID), 32'(s_id));
      chk("bp_hold_vld", 32'(RSP_VALID), 32'h8);
    end
    rdy_drv = 4'b1000;
    run(1);
    chk("bp_done", 32'(RSP_VALID), 32'h0);
    rdy_drv = '1;
    wait_rsp(n_rsp);
    run(2);

    // Reset while a response is waiting.
    rdy_drv = '0;
    pend[1] = 1;
    pa[1] = 32'h9;
    pb[1] = 32'h4;
    psub[1] = 0;
    wait_resp_phase();
    chk("mid_vld", 32'(RSP_VALID), 32'b0010);
    n0 = n_rsp;
    do_reset();
    chk("rst_vld", 32'(RSP_VALID), 32'h0);
    chk("rst_ans", RSP_ANS, 32'h0);
    chk("rst_id", 32'(RSP_ID), 32'h0);
    rdy_drv = '1;
    run(3);
    chk("rst_no_rsp", 32'(n_rsp), 32'(n0));
    // rr_ptr back at 0: requester 0 beats requester 3.
    pend[0] = 1;
    pa[0] = 32'h1;
    pb[0] = 32'h1;
    pend[3] = 1;
    pa[3] = 32'h2;
    pb[3] = 32'h2;
    run(1);
    chk("rst_ptr", 32'(g_log[$]), 32'd0);
    for (int b = 0; b < 20 && (pend[3] || m_phase != 0); b++)
      run(1);

`ifdef ADDSUB_SHARE_OVF_STICKY_EN
    run_one(2, 32'h7FFFFFFF, 32'h1, 0, 32'h80000000, 1);
    chk("sticky_set", 32'(OVF_STICKY), 32'b0100);
    clr_drv = 4'b0100;
    run(1);
    clr_drv = '0;
    run(1);
    chk("sticky_clr", 32'(OVF_STICKY), 32'b0000);
    rdy_drv = '0;
    pend[2] = 1;
    pa[2] = 32'h0;
    pb[2] = 32'h80000000;
    psub[2] = 1;
    wait_resp_phase();
    rdy_drv = '1;
    clr_drv = 4'b0100;
    run(1);
    clr_drv = '0;
    chk("sticky_win", 32'(OVF_STICKY), 32'b0100);
    run(1);
`endif

    // Random traffic.
    rnd_en = 1;
    run(600);
    rnd_en = 0;
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
    rdy_drv = '1;
    clr_drv = '0;
    run(6);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
